bcd_scan_display: RTL and testbench
===================================

// Module: bcd_scan_display
// PURPOSE
//   Downstream consumer of the cascaded 4-bit BCD counter stages (0..9 wrap, ENP/ENT chaining).
//   Snapshots a packed multi-digit BCD value and time-multiplexes it onto a common-segment
//   7-segment display: one digit enabled at a time, rotating at a prescaled scan rate.
//   Snapshots are applied only at frame boundaries, so the display never shows a torn value.
// PARAMETERS
//   DIGITS        4     number of BCD digits / display positions (2..8)
//   SCAN_DIV      1000  CLK cycles per digit slot (>=2)
//   COMMON_ANODE  0     1: SEG and AN outputs active-low; 0: active-high
// PORTS
//   CLK     in   1         system clock, rising edge
//   CLR     in   1         asynchronous active-low reset
//   BCD     in   4*DIGITS  packed digits, [3:0] = least significant digit
//   LOAD    in   1         snapshot request (level or pulse; sampled each CLK)
//   ACK     out  1         one-cycle pulse: snapshot applied
//   SEG     out  7         segments {g,f,e,d,c,b,a}
//   AN      out  DIGITS    one-hot digit enable, bit i = digit i
// BEHAVIOUR
//   Reset (CLR=0): prescaler=0, idx=0, disp=0, pend=0, ACK=0; SEG and AN at inactive level
//     (all 0 when COMMON_ANODE=0, all 1 when 1). Reset mid-frame aborts the frame and drops pend.
//   Prescaler: counts 0..SCAN_DIV-1 and wraps; tick = (prescaler==SCAN_DIV-1).
//   Digit index: on tick idx <= (idx==DIGITS-1) ? 0 : idx+1. frame_end = tick && idx==DIGITS-1.
//   Handshake: LOAD=1 sets pend. On frame_end with (pend || LOAD): disp <= BCD sampled that
//     cycle, pend <= 0, ACK=1 on the next cycle only. LOAD coincident with frame_end is captured
//     immediately. LOAD held high captures once per frame. Worst-case LOAD->ACK latency =
//     DIGITS*SCAN_DIV+1 cycles.
//   Outputs: registered; in the cycle after idx changes, AN = onehot(idx) and
//     SEG = decode(disp[4*idx+:4]) (1-cycle latency from idx/disp).
//   Decode (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; codes A..F show
//     dash 40 (invalid BCD is flagged, never wrapped). COMMON_ANODE=1 inverts SEG and AN.
//   Width rules: prescaler $clog2(SCAN_DIV) bits, idx $clog2(DIGITS) bits; no overflow past
//     the wrap values.
// CONFIGURATION
//   `LEADING_ZERO_BLANK_EN defined: digit i>0 is blanked (AN bit inactive, SEG inactive) when
//     disp digits i..DIGITS-1 are all 0; digit 0 is never blanked (value 0 shows "0").
//     Blanking uses the captured disp, not the live BCD input. Scan timing is unchanged.
//   Undefined: all digits always shown, leading zeros displayed.
// STRUCTURE
//   Package seg7_pkg: 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF; function
//     onehot(idx).
//   Sub-module bcd_to_seg7 (combinational 4-bit -> 7-bit decode), instantiated once on the
//     muxed digit. Prescaler, idx, handshake and output registers live in the top.
// TESTING (DIGITS=4, SCAN_DIV=4, COMMON_ANODE=0 unless stated)
//   1 Reset: CLR=0 mid-frame with pend=1 -> SEG=00, AN=0000, ACK=0; after release digit 0
//     shows "0" (SEG=3F, AN=0001); no ACK without a new LOAD.
//   2 Scan: BCD=16'h1234, LOAD pulse -> ACK after frame end; AN cycles 0001,0010,0100,1000
//     with 4 cycles each, SEG 66,4F,5B,06 respectively.
//   3 No tearing: LOAD in mid-frame, BCD changes 1234->5678 before frame_end -> 5678 captured
//     at frame_end, current frame shows only old value; one ACK pulse.
//   4 Simultaneous: LOAD asserted exactly on frame_end -> capture that cycle, ACK next cycle;
//     LOAD held high 3 frames -> exactly 3 ACK pulses.
//   5 Invalid/polarity: BCD=16'h00A9 -> digit1 SEG=40, digit0 SEG=6F; COMMON_ANODE=1 ->
//     SEG=~6F, AN=1110 on digit 0.
//   6 `LEADING_ZERO_BLANK_EN: BCD=16'h0007 -> only AN=0001 ever active, SEG=07;
//     BCD=16'h0000 -> digit 0 shows 3F; BCD=16'h0100 -> digits 0..2 shown, digit 3 blank.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants ({g,f,e,d,c,b,a}, active-high) and the one-hot digit-select helper.
package seg7_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
      logic [MAX_DIGITS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment driver: snapshots a packed BCD value at frame boundaries and scans it out.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_scan_display
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 1000,
   parameter bit COMMON_ANODE = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_clr_n,
   input  logic [4*DIGITS-1:0]   i_bcd,
   input  logic                  i_load,
   output logic                  o_ack,
   output logic [6:0]            o_seg,
   output logic [DIGITS-1:0]     o_an
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0]     PRE_MAX  = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     IDX_MAX  = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_IDLE = {7{COMMON_ANODE}};
   localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{COMMON_ANODE}};

   logic [PW-1:0]       r_prescaler;
   logic [IW-1:0]       r_idx;
   logic [4*DIGITS-1:0] r_disp;
   logic                r_pend;
   logic                r_ack;
   logic [6:0]          r_seg;
   logic [DIGITS-1:0]   r_an;

   logic                w_tick;
   logic                w_frame_end;
   logic                w_capture;
   logic [3:0]          w_digits [DIGITS];
   logic [3:0]          w_cur_digit;
   logic [6:0]          w_dec_seg;
   logic [DIGITS-1:0]   w_an_sel;
   logic                w_blank;

   assign w_tick      = (r_prescaler == PRE_MAX);
   assign w_frame_end = w_tick && (r_idx == IDX_MAX);
   // A LOAD arriving on the frame-end cycle itself is honoured without waiting for pend.
   assign w_capture   = w_frame_end && (r_pend || i_load);

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign w_digits[gi] = r_disp[4*gi +: 4];
      end
   endgenerate

   assign w_cur_digit = w_digits[r_idx];
   assign w_an_sel    = DIGITS'(onehot(3'(r_idx)));

   bcd_to_seg7 u_dec (
      .i_bcd (w_cur_digit),
      .o_seg (w_dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] w_upper_zero;

   // Bit i set when captured digits i..DIGITS-1 are all zero.
   always_comb begin
      w_upper_zero = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_upper_zero[i] = 1'b1;
         for (int j = i; j < DIGITS; j++) begin
            if (w_digits[j] != 4'd0) begin
               w_upper_zero[i] = 1'b0;
            end
         end
      end
   end

   assign w_blank = (r_idx != '0) && w_upper_zero[r_idx];
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_prescaler <= '0;
         r_idx       <= '0;
      end else if (w_tick) begin
         r_prescaler <= '0;
         r_idx       <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
         r_prescaler <= r_prescaler + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_disp <= '0;
         r_pend <= 1'b0;
         r_ack  <= 1'b0;
      end else begin
         r_ack <= w_capture;
         if (w_capture) begin
            r_disp <= i_bcd;
            r_pend <= 1'b0;
         end else if (i_load) begin
            r_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_seg <= SEG_IDLE;
         r_an  <= AN_IDLE;
      end else if (w_blank) begin
         r_seg <= SEG_IDLE;
         r_an  <= AN_IDLE;
      end else begin
         r_seg <= COMMON_ANODE ? ~w_dec_seg : w_dec_seg;
         r_an  <= COMMON_ANODE ? ~w_an_sel  : w_an_sel;
      end
   end

   assign o_ack = r_ack;
   assign o_seg = r_seg;
   assign o_an  = r_an;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomised scoreboard bench for bcd_scan_display (common-cathode and common-anode instances).
module tb_bcd_scan_display;

   localparam int D     = 4;
   localparam int S     = 4;
   localparam int FRAME = D * S;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        load;
   logic [15:0] bcd;
   logic        ack, ack_ca;
   logic [6:0]  seg, seg_ca;
   logic [3:0]  an, an_ca;

   always #5 clk = ~clk;

   bcd_scan_display #(.DIGITS(D), .SCAN_DIV(S), .COMMON_ANODE(1'b0)) u_dut (
      .i_clk(clk), .i_clr_n(clr_n), .i_bcd(bcd), .i_load(load),
      .o_ack(ack), .o_seg(seg), .o_an(an)
   );

   bcd_scan_display #(.DIGITS(D), .SCAN_DIV(S), .COMMON_ANODE(1'b1)) u_dut_ca (
      .i_clk(clk), .i_clr_n(clr_n), .i_bcd(bcd), .i_load(load),
      .o_ack(ack_ca), .o_seg(seg_ca), .o_an(an_ca)
   );

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] an;
      logic       ack;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ack_cnt  = 0;
   int   m_n      = 0;   // index of the next clock edge since reset release
   logic        m_pend = 1'b0;
   logic [15:0] m_disp = '0;

   function automatic logic [6:0] ref_seg(input int v);
      case (v)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // Display seen after an edge: the slot and snapshot in force before that edge.
   function automatic exp_t ref_out(input int slot, input logic [15:0] disp, input logic ackv);
      exp_t e;
      bit   blank;
      int   dv;
      dv    = int'((disp >> (4 * slot)) & 16'hF);
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0 && (disp >> (4 * slot)) == 16'h0) blank = 1'b1;
`endif
      e.ack = ackv;
      if (blank) begin
         e.seg = 7'h00;
         e.an  = 4'h0;
      end else begin
         e.seg = ref_seg(dv);
         e.an  = 4'(1 << slot);
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: one expected entry per clock edge.
   initial begin : model
      bit cap;
      forever begin
         @(posedge clk or negedge clr_n);
         if (!clr_n) begin
            exp_q.delete();
            m_pend = 1'b0;
            m_disp = '0;
            m_n    = 0;
            exp_q.push_back('0);
         end else begin
            cap = ((m_n % FRAME) == FRAME - 1) && (m_pend || load);
            exp_q.push_back(ref_out((m_n / S) % D, m_disp, cap));
            if (cap) begin
               m_disp = bcd;
               m_pend = 1'b0;
            end else if (load) begin
               m_pend = 1'b1;
            end
            m_n++;
         end
      end
   end

   initial begin : monitor
      exp_t       e;
      logic [6:0] inv_seg;
      logic [3:0] inv_an;
      forever begin
         @(negedge clk);
         if (ack) ack_cnt++;
         if (exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            inv_seg = ~e.seg;
            inv_an  = ~e.an;
            check("seg",    32'(seg),    32'(e.seg));
            check("an",     32'(an),     32'(e.an));
            check("ack",    32'(ack),    32'(e.ack));
            check("seg_ca", 32'(seg_ca), 32'(inv_seg));
            check("an_ca",  32'(an_ca),  32'(inv_an));
            check("ack_ca", 32'(ack_ca), 32'(e.ack));
         end
      end
   end

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at_pos(input int p);
      for (int i = 0; i < 2 * FRAME && (m_n % FRAME) != p; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_load();
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   initial begin : stimulus
      int          base;
      logic [15:0] vals [4];
      vals = '{16'h00A9, 16'h0007, 16'h0000, 16'h0100};
      clr_n = 1'b0;
      load  = 1'b0;
      bcd   = '0;
      repeat (3) @(posedge clk);
      #1 clr_n = 1'b1;
      idle(2 * FRAME);

      // Basic scan of 1234
      bcd = 16'h1234;
      at_pos(5);
      pulse_load();
      idle(3 * FRAME);

      // LOAD mid-frame, value changes before the frame boundary
      at_pos(3);
      pulse_load();
      at_pos(9);
      bcd = 16'h5678;
      idle(2 * FRAME);

      // LOAD exactly on the frame-end cycle
      bcd = 16'h4321;
      at_pos(15);
      pulse_load();
      idle(FRAME);

      // LOAD held for three whole frames
      bcd = 16'h9876;
      at_pos(0);
      base = ack_cnt;
      load = 1'b1;
      idle(3 * FRAME);
      load = 1'b0;
      idle(2);
      check("held_load_acks", 32'(ack_cnt - base), 32'd3);

      // Invalid digit and leading-zero patterns
      for (int k = 0; k < 4; k++) begin
         bcd = vals[k];
         at_pos(4);
         pulse_load();
         idle(2 * FRAME);
      end

      // Reset mid-frame while a request is pending
      bcd = 16'h2468;
      at_pos(6);
      pulse_load();
      idle(2);
      clr_n = 1'b0;
      idle(3);
      clr_n = 1'b1;
      base = ack_cnt;
      idle(3 * FRAME);
      check("ack_after_reset", 32'(ack_cnt - base), 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) bcd = 16'($urandom);
         load = ($urandom_range(0, 9) == 0);
         if (i == 200) clr_n = 1'b0;
         if (i == 203) clr_n = 1'b1;
         @(posedge clk);
         #1;
      end
      load = 1'b0;
      idle(FRAME + 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
